// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmitter: one byte per data_send/data_sent handshake, registered TXD.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
  parameter int   CLKS_PER_BIT = 868,
  parameter int   STOP_BITS    = 1,
  parameter logic PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_send,
  output logic       data_sent,
  output logic       uart_txd,
  output logic       busy
);

  // state    | meaning
  // s_idle   | line high, waiting for data_send
  // s_start  | start bit (low)
  // s_data   | 8 data bits, LSB first
  // s_parity | parity bit (only with UART_TX_PARITY_EN)
  // s_stop   | STOP_BITS stop bits (high)
  // s_done   | one-cycle data_sent pulse, then back to idle
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  state_t      state, state_d;
  logic [15:0] baud_cnt, baud_cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  data_q, data_d;
  logic        txd_d;
  logic        baud_end;

  assign baud_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      data_q    <= '0;
      uart_txd  <= 1'b1;
      data_sent <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      baud_cnt  <= baud_cnt_d;
      bit_idx   <= bit_idx_d;
      data_q    <= data_d;
      uart_txd  <= txd_d;
      data_sent <= (state_d == S_DONE);
      busy      <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt + 16'd1;
    bit_idx_d  = bit_idx;
    data_d     = data_q;
    case (state)
      S_IDLE: begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        if (data_send) begin
          data_d  = data_in;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = S_STOP;
        end
      end
`endif
      // bit_idx is reused to count stop bits
      S_STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_idx == STOP_LAST) begin
            bit_idx_d = '0;
            state_d   = S_DONE;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      S_DONE: begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        state_d    = S_IDLE;
      end
      default: begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Line level is derived from the next state so the flop holds it for the whole bit.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = data_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = (^data_q) ^ PARITY_ODD;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: two instances (1 and 2 stop bits) at 4 clocks/bit.
// Expected line levels come from a small frame model; parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       send1, send2;
  logic       sent1, sent2, txd1, txd2, busy1, busy2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_send(send1),
    .data_sent(sent1), .uart_txd(txd1), .busy(busy1)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1'b1)) dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_send(send2),
    .data_sent(sent2), .uart_txd(txd2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Level expected at bit position pos of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int pos, input logic odd);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (P == 1 && pos == 9) return (^b) ^ odd;
    return 1'b1;
  endfunction

  task automatic sample(input int sel, output logic t, output logic s, output logic bz);
    t  = (sel == 2) ? txd2  : txd1;
    s  = (sel == 2) ? sent2 : sent1;
    bz = (sel == 2) ? busy2 : busy1;
  endtask

  task automatic set_req(input int sel, input logic v);
    if (sel == 2) send2 = v;
    else          send1 = v;
  endtask

  // Called at a negedge with the selected DUT idle; returns at the first idle negedge after DONE.
  task automatic do_frame(input int sel, input logic [7:0] b, input bit toggle, input string tag);
    int   stops = (sel == 2) ? 2 : 1;
    logic odd   = (sel == 2) ? 1'b1 : 1'b0;
    int   len   = (9 + P + stops) * CPB;
    int   bcnt  = 0;
    int   scnt  = 0;
    logic t, s, bz;
    data_in = b;
    set_req(sel, 1'b1);
    @(posedge clk);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      sample(sel, t, s, bz);
      chk($sformatf("%s_txd_c%0d", tag, k), {31'd0, t}, {31'd0, exp_bit(b, k / CPB, odd)});
      if (s)  scnt++;
      if (bz) bcnt++;
      if (toggle) data_in = 8'($urandom);
    end
    @(negedge clk);
    sample(sel, t, s, bz);
    chk({tag, "_done_sent"}, {31'd0, s}, 32'd1);
    chk({tag, "_done_txd"}, {31'd0, t}, 32'd1);
    if (bz) bcnt++;
    chk({tag, "_early_sent"}, scnt, 0);
    chk({tag, "_busy_len"}, bcnt, len + 1);
    @(negedge clk);
    sample(sel, t, s, bz);
    chk({tag, "_idle_busy"}, {31'd0, bz}, 32'd0);
    chk({tag, "_idle_sent"}, {31'd0, s}, 32'd0);
    set_req(sel, 1'b0);
  endtask

  initial begin
    int quiet;
    rst     = 1'b1;
    send1   = 1'b0;
    send2   = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd1", {31'd0, txd1}, 32'd1);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_sent1", {31'd0, sent1}, 32'd0);
    chk("rst_txd2", {31'd0, txd2}, 32'd1);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_frame(1, 8'h55, 1'b0, "f55");

    // Back-to-back: second request raised on the first idle cycle after DONE.
    do_frame(1, 8'hA3, 1'b0, "fa3");
    do_frame(1, 8'h0F, 1'b0, "f0f");
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy1 || !txd1 || sent1) quiet++;
    end
    chk("no_third_frame", quiet, 0);

    // Abort 0xFF during data bit 3 (cycles 16..19 after the start edge).
    data_in = 8'hFF;
    send1   = 1'b1;
    @(posedge clk);
    repeat (18) @(negedge clk);
    chk("pre_abort_txd", {31'd0, txd1}, 32'd1);
    chk("pre_abort_busy", {31'd0, busy1}, 32'd1);
    rst   = 1'b1;
    send1 = 1'b0;
    @(negedge clk);
    chk("abort_txd", {31'd0, txd1}, 32'd1);
    chk("abort_busy", {31'd0, busy1}, 32'd0);
    chk("abort_sent", {31'd0, sent1}, 32'd0);
    rst = 1'b0;
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (sent1 || busy1 || !txd1) quiet++;
    end
    chk("abort_quiet", quiet, 0);
    do_frame(1, 8'h00, 1'b0, "f00");

    do_frame(2, 8'h80, 1'b0, "s2_80");
    do_frame(1, 8'h07, 1'b0, "f07");
    do_frame(2, 8'h07, 1'b0, "s2_07");
    do_frame(1, 8'h03, 1'b0, "f03");
    do_frame(1, 8'h3C, 1'b1, "f3c_tog");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
